// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 keyboard controller.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, EXT, BRK, PAUSE} ps2_parse_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_AA = 8'hAA;
  localparam logic [7:0] PS2_FA = 8'hFA;
  localparam logic [7:0] PS2_FC = 8'hFC;
  localparam logic [7:0] PS2_EE = 8'hEE;
  localparam logic [7:0] PS2_FE = 8'hFE;

  // Pause/Break collapses to this code once its 8-byte sequence is swallowed
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO; head is valid whenever empty is low.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  ps2_evt_t                    din,
  output logic                        full,
  input  logic                        pop,
  output ps2_evt_t                    dout,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  ps2_evt_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push at full still lands
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Scan-code set 2 parser with event FIFO, receiver gating and stall watchdog.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 150_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_idle,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       rx_rst,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic [7:0] evt_code,
  output logic       bat_ok_tick,
  output logic       ack_tick,
  output logic       err_kbd,
  output logic       err_ovf,
  output logic       err_to
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_TERM  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE   = 1;

  ps2_parse_t    state;
  logic          ext_q;
  logic [2:0]    skip_cnt;
  logic [TW-1:0] to_cnt;
  logic          wd_fire, byte_ok;
  logic          push_req, pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  ps2_evt_t      push_evt, head;

  assign wd_fire   = (to_cnt == TO_TERM);
  // The watchdog outranks a byte arriving on the terminal cycle
  assign byte_ok   = rx_done_tick & ~wd_fire;
  assign rx_en     = (fifo_count < CNT_FULL);
  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;
  assign evt_code  = head.code;

  always_comb begin
    push_req = 1'b0;
    push_evt = '{ext: ext_q, brk: 1'b0, code: rx_data};
    if (byte_ok) begin
      case (state)
        IDLE:  push_req = !(rx_data inside {PS2_E0, PS2_F0, PS2_E1, PS2_AA, PS2_FA,
                                            PS2_FC, 8'h00, 8'hFF, PS2_EE, PS2_FE});
        EXT:   if (rx_data != PS2_F0) begin
                 push_req     = 1'b1;
                 push_evt.ext = 1'b1;
               end
        BRK: begin
          push_req     = 1'b1;
          push_evt.brk = 1'b1;
        end
        PAUSE: if (skip_cnt == 3'd1) begin
                 push_req = 1'b1;
                 push_evt = '{ext: 1'b1, brk: 1'b0, code: PS2_PAUSE_CODE};
               end
        default: push_req = 1'b0;
      endcase
    end
  end

  ps2_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .din     (push_evt),
    .full    (fifo_full),
    .pop     (pop),
    .dout    (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ext_q       <= 1'b0;
      skip_cnt    <= '0;
      to_cnt      <= '0;
      rx_rst      <= 1'b0;
      bat_ok_tick <= 1'b0;
      ack_tick    <= 1'b0;
      err_kbd     <= 1'b0;
      err_ovf     <= 1'b0;
      err_to      <= 1'b0;
    end else begin
      bat_ok_tick <= byte_ok && state == IDLE && rx_data == PS2_AA;
      ack_tick    <= byte_ok && state == IDLE && rx_data == PS2_FA;
      err_kbd     <= byte_ok && state == IDLE &&
                     (rx_data inside {PS2_FC, 8'h00, 8'hFF});
      err_ovf     <= push_req & fifo_full & ~pop;
      rx_rst      <= wd_fire;
      err_to      <= wd_fire;
      if (wd_fire) begin
        state  <= IDLE;
        ext_q  <= 1'b0;
        to_cnt <= '0;
      end else begin
        if (rx_done_tick || (rx_idle && state == IDLE)) to_cnt <= '0;
        else if (to_cnt != TO_TERM)                     to_cnt <= to_cnt + TO_ONE;
        if (rx_done_tick) begin
          case (state)
            IDLE:
              if (rx_data == PS2_E0) begin
                ext_q <= 1'b1;
                state <= EXT;
              end else if (rx_data == PS2_F0) begin
                state <= BRK;
              end else if (rx_data == PS2_E1) begin
                skip_cnt <= PS2_PAUSE_SKIP;
                state    <= PAUSE;
              end
            EXT:
              if (rx_data == PS2_F0) state <= BRK;
              else begin
                ext_q <= 1'b0;
                state <= IDLE;
              end
            BRK: begin
              ext_q <= 1'b0;
              state <= IDLE;
            end
            PAUSE: begin
              skip_cnt <= skip_cnt - 3'd1;
              if (skip_cnt == 3'd1) begin
                ext_q <= 1'b0;
                state <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
